// File: rtl/shared_reg_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// shared_reg_arbiter_pkg
// Shared constants for the shared register write arbiter: FSM state width and
// state encodings. Imported by the arbiter top.
// -----------------------------------------------------------------------------
package shared_reg_arbiter_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shared_reg_arbiter_parallel_register.sv
// -----------------------------------------------------------------------------
// parallel_register
// Plain X-bit holding register with a synchronous load enable.
//
// Ports:
//   clk      input   1  rising-edge clock
//   rst      input   1  asynchronous active-high reset, clears q
//   load     input   1  capture data_in on the next rising edge
//   data_in  input   x  word to capture
//   q        output  x  register contents
// -----------------------------------------------------------------------------
module parallel_register #(
    parameter int x = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [x-1:0] data_in,
    output logic [x-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= data_in;
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// -----------------------------------------------------------------------------
// shared_reg_arbiter
// Round-robin write arbiter sharing one parallel_register among N requesters.
// A winner is picked in IDLE, its word is loaded in LOAD (provided it still
// requests), and a one-cycle done pulse is issued in DONE.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | waiting; round-robin pick from req starting at ptr
//   LOAD    | gnt visible; load the winner's word if req[sel] still high
//   DONE    | q holds the new word; done[sel] pulses; ptr advances on exit
//
// Ports:
//   clk    input   1     rising-edge clock
//   rst    input   1     asynchronous active-high reset
//   req    input   N     level request per requester
//   wdata  input   N*X   requester i's word at wdata[i*X +: X]
//   gnt    output  N     registered grant, one-hot or zero
//   done   output  N     one-cycle pulse to the requester that committed
//   q      output  X     shared register contents
//   owner  output  W     index of the last requester that committed
//   busy   output  1     high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
import shared_reg_arbiter_pkg::*;

module shared_reg_arbiter #(
    parameter int X = 8,
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*X-1:0] wdata,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   done,
    output logic [X-1:0]   q,
    output logic [W-1:0]   owner,
    output logic           busy
);

    state_t         state;
    logic [W-1:0]   sel;
    logic [W-1:0]   ptr;
    logic [W-1:0]   pick_idx;
    logic [W-1:0]   ptr_next;
    logic           load;
    logic [X-1:0]   data_in;

    // Rotate req down by p so index p sits at bit 0, take the lowest set bit,
    // then add p back modulo N.
    function automatic logic [W-1:0] rr_pick(input logic [N-1:0] r,
                                             input logic [W-1:0] p);
        logic [2*N-1:0] dbl;
        logic [N-1:0]   rot;
        int unsigned    off;
        int unsigned    idx;
        logic           found;
        dbl   = {r, r} >> p;
        rot   = dbl[N-1:0];
        off   = 0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                off   = unsigned'(i);
                found = 1'b1;
            end
        end
        idx = 32'(p) + off;
        if (idx >= unsigned'(N)) begin
            idx = idx - unsigned'(N);
        end
        return idx[W-1:0];
    endfunction

    function automatic logic [N-1:0] to_onehot(input logic [W-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign pick_idx = rr_pick(req, ptr);
    assign ptr_next = (sel == W'(N - 1)) ? '0 : sel + 1'b1;

    // A withdrawn request in LOAD suppresses the write entirely.
    assign load    = (state == ST_LOAD) && req[sel];
    assign data_in = wdata[int'(sel)*X +: X];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            gnt   <= '0;
            done  <= '0;
            ptr   <= '0;
            sel   <= '0;
            owner <= '0;
            busy  <= 1'b0;
        end else begin
            done <= '0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        sel   <= pick_idx;
                        gnt   <= to_onehot(pick_idx);
                        state <= ST_LOAD;
                        busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (req[sel]) begin
                        done  <= to_onehot(sel);
                        owner <= sel;
                        state <= ST_DONE;
                    end else begin
                        // Abort: ptr stays put so the same priority order applies.
                        gnt   <= '0;
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    ptr   <= ptr_next;
                    gnt   <= '0;
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    gnt   <= '0;
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    parallel_register #(.x(X)) u_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .data_in (data_in),
        .q       (q)
    );

endmodule

// File: tb/tb_shared_reg_arbiter.sv
module tb_shared_reg_arbiter;

    localparam int N = 4;
    localparam int X = 8;
    localparam int W = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*X-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic [X-1:0]   q;
    logic [W-1:0]   owner;
    logic           busy;

    shared_reg_arbiter #(.X(X), .N(N), .W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .wdata (wdata),
        .gnt   (gnt),
        .done  (done),
        .q     (q),
        .owner (owner),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned own;
        logic [X-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   stamps[$];
    int   total = 0;
    int   bad = 0;
    int   ndone = 0;
    int   cyc = 0;
    logic done_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: compare every done pulse against the head of the scoreboard.
    always @(negedge clk) begin
        exp_t         e;
        logic [N-1:0] exp_done;
        check("gnt_onehot0", 32'($countones(gnt) <= 1), 32'd1);
        if (|done) begin
            check("done_not_consecutive", 32'(done_prev), 32'd0);
            ndone++;
            stamps.push_back(cyc);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: done=%b q=%h, want no done", done, q);
            end else begin
                e        = sb.pop_front();
                exp_done = '0;
                exp_done[e.own] = 1'b1;
                check("done_vec", 32'(done), 32'(exp_done));
                check("q_commit", 32'(q), 32'(e.data));
                check("owner_commit", 32'(owner), e.own);
            end
        end
        done_prev = |done;
    end

    task automatic set_word(input int i, input logic [X-1:0] v);
        wdata[i*X +: X] = v;
    endtask

    task automatic expect_commit(input int unsigned own, input logic [X-1:0] d);
        exp_t e;
        e.own  = own;
        e.data = d;
        sb.push_back(e);
    endtask

    // Drive req during an IDLE cycle; returns #1 into the LOAD cycle.
    task automatic request(input logic [N-1:0] r, input logic [N-1:0] exp_gnt, input string name);
        req = r;
        @(posedge clk);
        #1;
        check(name, 32'(gnt), 32'(exp_gnt));
        check("busy_load", 32'(busy), 32'd1);
    endtask

    // Returns #1 into the IDLE cycle that follows the target done.
    task automatic wait_dones(input int target, input int budget, input string name);
        int k = 0;
        while (ndone < target && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(name, 32'(ndone), 32'(target));
    endtask

    initial begin
        int n0;
        rst   = 1'b1;
        req   = '0;
        wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_q", 32'(q), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Fairness: all four requesting, served 0,1,2,3,0 three cycles apart.
        set_word(0, 8'h11);
        set_word(1, 8'h22);
        set_word(2, 8'h33);
        set_word(3, 8'h44);
        expect_commit(0, 8'h11);
        expect_commit(1, 8'h22);
        expect_commit(2, 8'h33);
        expect_commit(3, 8'h44);
        expect_commit(0, 8'h11);
        stamps.delete();
        request(4'b1111, 4'b0001, "gnt_fair_first");
        wait_dones(ndone + 5, 30, "fair_done_count");
        req = '0;
        for (int i = 0; i < 4; i++) begin
            if (stamps.size() > i + 1)
                check("fair_done_gap", 32'(stamps[i+1] - stamps[i]), 32'd3);
        end

        // Commit by requester 3, then 1001 wraps to requester 0.
        set_word(3, 8'h44);
        expect_commit(3, 8'h44);
        request(4'b1000, 4'b1000, "gnt_r3");
        wait_dones(ndone + 1, 10, "r3_done");
        req = '0;
        set_word(0, 8'hA0);
        expect_commit(0, 8'hA0);
        request(4'b1001, 4'b0001, "gnt_wrap");
        wait_dones(ndone + 1, 10, "wrap_done");
        req = '0;

        // Single requester 2.
        set_word(2, 8'hB6);
        expect_commit(2, 8'hB6);
        request(4'b0100, 4'b0100, "gnt_single");
        wait_dones(ndone + 1, 10, "single_done");
        check("single_idle_busy", 32'(busy), 32'd0);
        check("single_q_hold", 32'(q), 32'hB6);
        req = '0;

        // Withdrawal during LOAD: nothing commits, ptr stays at 3.
        set_word(1, 8'h99);
        n0 = ndone;
        request(4'b0010, 4'b0010, "gnt_withdraw");
        req = '0;
        @(posedge clk);
        #1;
        check("wd_gnt", 32'(gnt), 32'd0);
        check("wd_busy", 32'(busy), 32'd0);
        check("wd_q", 32'(q), 32'hB6);
        check("wd_owner", 32'(owner), 32'd2);
        repeat (3) @(posedge clk);
        #1;
        check("wd_no_done", 32'(ndone), 32'(n0));
        // From ptr 3, 0101 goes to 0; a wrongly advanced ptr (2) would pick 2.
        set_word(0, 8'hC3);
        set_word(2, 8'hD4);
        expect_commit(0, 8'hC3);
        request(4'b0101, 4'b0001, "gnt_ptr_kept");
        wait_dones(ndone + 1, 10, "ptr_kept_done");
        req = '0;

        // Reset in the middle of LOAD.
        set_word(1, 8'h55);
        n0 = ndone;
        request(4'b0010, 4'b0010, "gnt_pre_rst");
        #2;
        rst = 1'b1;
        #1;
        check("midrst_q", 32'(q), 32'd0);
        check("midrst_gnt", 32'(gnt), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_owner", 32'(owner), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = '0;
        repeat (4) @(posedge clk);
        #1;
        check("midrst_no_done", 32'(ndone), 32'(n0));
        check("midrst_q_still0", 32'(q), 32'd0);
        // ptr back at 0: 0101 picks 0 (a stale ptr of 1 would pick 2).
        set_word(0, 8'h55);
        set_word(2, 8'h77);
        expect_commit(0, 8'h55);
        request(4'b0101, 4'b0001, "gnt_after_rst");
        wait_dones(ndone + 1, 10, "after_rst_done");
        req = '0;
        repeat (3) @(posedge clk);
        #1;

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
